i2s_adc_rx: RTL and testbench

- I2S receiver for the WM8750 ADC path, the capture-side counterpart of the existing DAC playback path.
- The FPGA is I2S master: bclk and adclrck are generated elsewhere. This block only oversamples bclk, adclrck and adcdat in the clk100 domain.
- It deserializes MSB-first stereo words and presents each left/right pair on a valid/ready interface for the SoC or NES audio mixer.
- It detects overruns and, optionally, short slots.

---
 rtl/i2s_adc_rx.sv | 174 +++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// I2S capture receiver for the WM8750 ADC: oversamples bclk/lrclk/adcdat in clk100 and presents stereo pairs on valid/ready.
// Define I2S_ADC_RX_FRAME_CHECK_EN to build the short/long slot checker that drives frame_err_o.
module i2s_adc_rx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                bclk_i,
    input  logic                lrclk_i,
    input  logic                adcdat_i,
    output logic [SAMPLE_W-1:0] sample_left_o,
    output logic [SAMPLE_W-1:0] sample_right_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    input  logic                clear_i,
    output logic                frame_err_o
);
    localparam int CW = $clog2(SAMPLE_W + 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, dat_sync;
    logic                   bclk_prev, bit_edge, ws_smp, dat_smp, ws_prev;
    state_t                 state;
    logic [CW-1:0]          bit_cnt, cnt_shift, pad;
    logic [SAMPLE_W-1:0]    shreg, sr_shift, word, left_hold, pair_l, pair_r;
    logic                   have_left, pair_pend, boundary;

    // Identical chains keep word select and data aligned with the bit clock.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            dat_sync  <= '0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_i};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat_i};
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            bclk_prev <= 1'b0;
            bit_edge  <= 1'b0;
            ws_smp    <= 1'b0;
            dat_smp   <= 1'b0;
        end else begin
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            bit_edge  <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
            ws_smp    <= lr_sync[SYNC_STAGES-1];
            dat_smp   <= dat_sync[SYNC_STAGES-1];
        end
    end

    always_comb begin
        boundary  = bit_edge && (ws_smp != ws_prev);
        sr_shift  = shreg;
        cnt_shift = bit_cnt;
        if (bit_cnt < CW'(SAMPLE_W)) begin
            sr_shift  = {shreg[SAMPLE_W-2:0], dat_smp};
            cnt_shift = bit_cnt + 1'b1;
        end
        // Short slots are left-aligned with zeros filling the missing LSBs.
        pad  = CW'(SAMPLE_W) - cnt_shift;
        word = sr_shift << pad;
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ws_prev   <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            have_left <= 1'b0;
            pair_pend <= 1'b0;
            pair_l    <= '0;
            pair_r    <= '0;
        end else begin
            pair_pend <= 1'b0;
            if (bit_edge) begin
                ws_prev <= ws_smp;
                case (state)
                    IDLE: begin
                        if (boundary) begin
                            state   <= RUN;
                            bit_cnt <= '0;
                            shreg   <= '0;
                        end
                    end
                    RUN: begin
                        if (!boundary) begin
                            shreg   <= sr_shift;
                            bit_cnt <= cnt_shift;
                        end else begin
                            shreg   <= '0;
                            bit_cnt <= '0;
                            if (!ws_prev) begin
                                left_hold <= word;
                                have_left <= 1'b1;
                            end else if (have_left) begin
                                pair_pend <= 1'b1;
                                pair_l    <= left_hold;
                                pair_r    <= word;
                                have_left <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            sample_left_o  <= '0;
            sample_right_o <= '0;
            valid_o        <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            if (pair_pend && (!valid_o || ready_i)) begin
                sample_left_o  <= pair_l;
                sample_right_o <= pair_r;
                valid_o        <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (pair_pend && valid_o && !ready_i)
                overrun_o <= 1'b1;
            else if (clear_i)
                overrun_o <= 1'b0;
        end
    end

`ifdef I2S_ADC_RX_FRAME_CHECK_EN
    localparam logic [6:0] LONG_LIM = 7'(SAMPLE_W + 16);

    logic [5:0] slot_cnt;
    logic [6:0] slot_len;
    logic       short_slot, long_slot;

    always_comb begin
        slot_len   = (slot_cnt == 6'h3f) ? 7'h3f : ({1'b0, slot_cnt} + 7'd1);
        short_slot = (state == RUN) && boundary && (cnt_shift < CW'(SAMPLE_W));
        long_slot  = (state == RUN) && bit_edge && (slot_len > LONG_LIM);
    end

    // Slot length counts every edge of the slot, including its closing boundary bit.
    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            slot_cnt    <= '0;
            frame_err_o <= 1'b0;
        end else begin
            if (bit_edge) begin
                if (boundary)
                    slot_cnt <= '0;
                else if (state == RUN)
                    slot_cnt <= slot_len[5:0];
            end
            if (short_slot || long_slot)
                frame_err_o <= 1'b1;
            else if (clear_i)
                frame_err_o <= 1'b0;
        end
    end
`else
    assign frame_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: table of stereo frames plus hand sequences for latency, reset, overrun and slot checks.
module tb_i2s_adc_rx;
    localparam int SW = 16;
    localparam int SS = 2;
`ifdef I2S_ADC_RX_FRAME_CHECK_EN
    localparam logic FE = 1'b1;
`else
    localparam logic FE = 1'b0;
`endif

    logic clk100 = 1'b0, rst = 1'b1, bclk_i = 1'b0, lrclk_i = 1'b0, adcdat_i = 1'b0;
    logic ready_i = 1'b0, clear_i = 1'b0;
    logic [SW-1:0] sample_left_o, sample_right_o;
    logic valid_o, overrun_o, frame_err_o;

    always #5 clk100 = ~clk100;

    i2s_adc_rx #(.SAMPLE_W(SW), .SYNC_STAGES(SS)) dut (
        .clk100(clk100), .rst(rst), .bclk_i(bclk_i), .lrclk_i(lrclk_i), .adcdat_i(adcdat_i),
        .sample_left_o(sample_left_o), .sample_right_o(sample_right_o), .valid_o(valid_o),
        .ready_i(ready_i), .overrun_o(overrun_o), .clear_i(clear_i), .frame_err_o(frame_err_o)
    );

    int checks = 0, errors = 0;
    logic [31:0] got_q[$];
    logic pending = 1'b0, skip_first = 1'b0;

    // Every accepted pair, recorded just before the handshake edge.
    always @(negedge clk100) if (!rst && valid_o && ready_i) got_q.push_back({sample_left_o, sample_right_o});

    typedef struct {
        int          slot;
        logic [15:0] l, r, pad, exp_l, exp_r;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic ws, input logic d);
        bclk_i = 1'b0; lrclk_i = ws; adcdat_i = d;
        ticks(5);
        bclk_i = 1'b1;
        ticks(5);
    endtask

    // First edge of a slot carries the previous slot's last bit (one-bit delay).
    task automatic send_slot(input logic ws, input logic [31:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            logic b;
            if (i == 0) begin
                if (skip_first) begin
                    skip_first = 1'b0;
                    continue;
                end
                b = pending;
            end else begin
                b = (i - 1 < 32) ? c[31-(i-1)] : 1'b0;
            end
            send_bit(ws, b);
        end
        pending = (n - 1 < 32) ? c[31-(n-1)] : 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic [15:0] pad, input int n);
        send_slot(1'b0, {l, pad}, n);
        send_slot(1'b1, {r, pad}, n);
    endtask

    task automatic send_tail();
        send_bit(1'b0, pending);
        skip_first = 1'b1;
        ticks(3);
    endtask

    task automatic do_reset();
        rst = 1'b1; bclk_i = 1'b0; lrclk_i = 1'b0; adcdat_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
        ticks(3);
        rst = 1'b0; pending = 1'b0; skip_first = 1'b0;
        ticks(2);
    endtask

    task automatic check_pairs(input string name, input int base, input logic [31:0] exp);
        logic [31:0] g;
        check({name, "_count"}, 32'(got_q.size() - base), 32'd1);
        g = (base < got_q.size()) ? got_q[base] : 32'hxxxxxxxx;
        check({name, "_pair"}, g, exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, base;
        logic seen;

        tbl[0] = '{32, 16'h1234, 16'hABCD, 16'h0000, 16'h1234, 16'hABCD};
        tbl[1] = '{16, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001};
        tbl[2] = '{24, 16'h8001, 16'h7FFE, 16'hFFFF, 16'h8001, 16'h7FFE};
        tbl[3] = '{20, 16'h0000, 16'hFFFF, 16'hAAAA, 16'h0000, 16'hFFFF};
        tbl[4] = '{32, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'hA5A5, 16'h5A5A};
        tbl[5] = '{17, 16'hC3C3, 16'h3C3C, 16'h8000, 16'hC3C3, 16'h3C3C};

        // Reset state, then latency of the first pair.
        do_reset();
        check("reset_outputs", {valid_o, overrun_o, frame_err_o, 13'd0}, 32'd0);
        check("reset_samples", {sample_left_o, sample_right_o}, 32'd0);
        ready_i = 1'b1;
        send_frame(16'h0, 16'h0, 16'h0, 32);
        send_frame(16'h1234, 16'hABCD, 16'h0, 32);
        check("no_pair_before_boundary", {31'd0, valid_o}, 32'd0);
        bclk_i = 1'b0; lrclk_i = 1'b0; adcdat_i = pending;
        ticks(5);
        bclk_i = 1'b1;
        k = 0; seen = 1'b0;
        while (k < 20 && !seen) begin
            @(posedge clk100);
            k++;
            @(negedge clk100);
            if (valid_o) seen = 1'b1;
        end
        check("latency", 32'(k - 1), 32'(SS + 2));
        check("latency_pair", {sample_left_o, sample_right_o}, 32'h1234ABCD);
        @(negedge clk100);
        check("valid_one_pulse", {31'd0, valid_o}, 32'd0);
        tick();
        skip_first = 1'b1;
        ticks(2);

        // Table of frames with various slot widths, ready held high.
        do_reset();
        ready_i = 1'b1;
        send_frame(16'h0, 16'h0, 16'h0, 32);
        base = got_q.size();
        for (int i = 0; i < 6; i++) send_frame(tbl[i].l, tbl[i].r, tbl[i].pad, tbl[i].slot);
        send_tail();
        check("tbl_count", 32'(got_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] g;
            g = (base + i < got_q.size()) ? got_q[base+i] : 32'hxxxxxxxx;
            check($sformatf("tbl_%0d", i), g, {tbl[i].exp_l, tbl[i].exp_r});
        end
        check("tbl_frame_err", {31'd0, frame_err_o}, 32'd0);
        check("tbl_overrun", {31'd0, overrun_o}, 32'd0);

        // Reset released in the middle of a right slot.
        do_reset();
        ready_i = 1'b1;
        send_slot(1'b0, 32'h0, 32);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 22; i++) send_bit(1'b1, 1'b0);
        pending = 1'b0; skip_first = 1'b0;
        base = got_q.size();
        send_frame(16'h0F0F, 16'hF0F0, 16'h0, 32);
        send_tail();
        check_pairs("mid_right", base, 32'h0F0FF0F0);

        // Overrun with ready low, clear, then ready in the exact load cycle.
        do_reset();
        send_frame(16'h0, 16'h0, 16'h0, 32);
        base = got_q.size();
        send_frame(16'h1111, 16'h2222, 16'h0, 32);
        send_frame(16'h3333, 16'h4444, 16'h0, 32);
        send_tail();
        check("ovr_valid", {31'd0, valid_o}, 32'd1);
        check("ovr_hold_pair", {sample_left_o, sample_right_o}, 32'h11112222);
        check("ovr_flag", {31'd0, overrun_o}, 32'd1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("ovr_cleared", {31'd0, overrun_o}, 32'd0);
        check("ovr_still_valid", {sample_left_o, sample_right_o, 15'd0, valid_o} >> 16, 32'h11112222);
        send_frame(16'h5678, 16'h9ABC, 16'h0, 32);
        bclk_i = 1'b0; lrclk_i = 1'b0; adcdat_i = pending;
        ticks(5);
        bclk_i = 1'b1;
        ticks(SS + 2);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("exact_valid", {31'd0, valid_o}, 32'd1);
        check("exact_pair", {sample_left_o, sample_right_o}, 32'h56789ABC);
        check("exact_no_overrun", {31'd0, overrun_o}, 32'd0);
        check_pairs("exact_consumed", base, 32'h11112222);
        skip_first = 1'b1;
        ticks(2);

        // Short left slot, then an over-long left slot.
        do_reset();
        ready_i = 1'b1;
        send_frame(16'h0, 16'h0, 16'h0, 32);
        base = got_q.size();
        send_slot(1'b0, {12'hABC, 20'h0}, 12);
        send_slot(1'b1, {16'h5A5A, 16'h0}, 32);
        send_tail();
        check_pairs("short", base, 32'hABC05A5A);
        check("short_frame_err", {31'd0, frame_err_o}, {31'd0, FE});
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("frame_err_cleared", {31'd0, frame_err_o}, 32'd0);
        base = got_q.size();
        send_slot(1'b0, {16'hBEEF, 16'h0}, 40);
        send_slot(1'b1, {16'hCAFE, 16'h0}, 32);
        send_tail();
        check_pairs("long", base, 32'hBEEFCAFE);
        check("long_frame_err", {31'd0, frame_err_o}, {31'd0, FE});

        // Reset pulsed mid left word while a pair is held.
        do_reset();
        send_frame(16'h0, 16'h0, 16'h0, 32);
        send_frame(16'h7777, 16'h8888, 16'h0, 32);
        send_bit(1'b0, pending);
        for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b1);
        check("pre_reset_pair", {sample_left_o, sample_right_o}, 32'h77778888);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {valid_o, overrun_o, frame_err_o, 13'd0}, 32'd0);
        check("async_reset_samples", {sample_left_o, sample_right_o}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 22; i++) send_bit(1'b0, 1'b1);
        pending = 1'b0; skip_first = 1'b0;
        ready_i = 1'b1;
        base = got_q.size();
        send_slot(1'b1, 32'hFFFF_FFFF, 32);
        send_frame(16'h5555, 16'hAAAA, 16'h0, 32);
        send_tail();
        check_pairs("mid_left", base, 32'h5555AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
